// File: rtl/mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux3_rr_arbiter: round-robin arbiter sharing one registered 3:1 data mux
// Revision: 1.0
// ============================================================================
module mux3_rr_arbiter #(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         req_b,
  input  logic         req_c,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         gnt_c,
  output logic         sel1,
  output logic         sel2,
  output logic [W-1:0] y,
  output logic         y_valid
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_C    = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     last, last_nxt;
  logic [1:0]     sel, sel_nxt;
  logic [2:0]     gnt, gnt_nxt;
  logic [CW-1:0]  burst_cnt, burst_cnt_nxt;
  logic [2:0]     req;
  logic [1:0]     cand1, cand2;

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == SRC_C || s == SRC_NONE) ? SRC_A : s + 2'd1;
  endfunction

  // In OWN, `last` is the current owner; candidates follow it in RR order.
  always_comb begin
    state_nxt     = IDLE;
    last_nxt      = last;
    sel_nxt       = SRC_NONE;
    burst_cnt_nxt = '0;
    gnt_nxt       = 3'b000;
    req           = {req_c, req_b, req_a};
    cand1         = rr_next(last);
    cand2         = rr_next(cand1);

    if (state == OWN && req[last] && burst_cnt < CW'(MAX_BURST)) begin
      state_nxt     = OWN;
      sel_nxt       = last;
      burst_cnt_nxt = burst_cnt + CW'(1);
    end else begin
      if (req[cand1])      sel_nxt = cand1;
      else if (req[cand2]) sel_nxt = cand2;
      else if (req[last])  sel_nxt = last;
      if (sel_nxt != SRC_NONE) begin
        state_nxt     = OWN;
        last_nxt      = sel_nxt;
        burst_cnt_nxt = CW'(1);
      end
    end

    case (sel_nxt)
      SRC_A:   gnt_nxt = 3'b001;
      SRC_B:   gnt_nxt = 3'b010;
      SRC_C:   gnt_nxt = 3'b100;
      default: gnt_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= SRC_C;
      sel       <= SRC_NONE;
      gnt       <= 3'b000;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Data path uses the select/grant registered at the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      case (sel)
        SRC_A:   y <= a;
        SRC_B:   y <= b;
        SRC_C:   y <= c;
        default: y <= '0;
      endcase
      y_valid <= |gnt;
    end
  end

  assign gnt_a = gnt[0];
  assign gnt_b = gnt[1];
  assign gnt_c = gnt[2];
  assign sel1  = sel[1];
  assign sel2  = sel[0];

endmodule
`default_nettype wire

// File: tb/tb_mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux3_rr_arbiter: directed scoreboard bench for mux3_rr_arbiter
// Revision: 1.0
// ============================================================================
module tb_mux3_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b1, req_b = 1'b1, req_c = 1'b1;
  logic [7:0] a = 8'h11, b = 8'h22, c = 8'h33;

  logic       gnt_a, gnt_b, gnt_c, sel1, sel2, y_valid;
  logic [7:0] y;
  logic       gnt1_a, gnt1_b, gnt1_c, sel1_1, sel2_1, y1_valid;
  logic [7:0] y1;

  int checks = 0;
  int failures = 0;
  logic [1:0] yq[$];

  always #5 clk = ~clk;

  mux3_rr_arbiter #(.W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .a(a), .b(b), .c(c), .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .sel1(sel1), .sel2(sel2), .y(y), .y_valid(y_valid)
  );

  mux3_rr_arbiter #(.W(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .a(a), .b(b), .c(c), .gnt_a(gnt1_a), .gnt_b(gnt1_b), .gnt_c(gnt1_c),
    .sel1(sel1_1), .sel2(sel2_1), .y(y1), .y_valid(y1_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] gnt_of(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] data_of(input logic [1:0] s);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'({gnt_c, gnt_b, gnt_a}), 32'(3'b000));
    check({tag, "_sel"}, 32'({sel1, sel2}), 32'(2'b11));
    check({tag, "_y"}, 32'(y), 32'(8'h00));
    check({tag, "_y_valid"}, 32'(y_valid), 32'(1'b0));
  endtask

  // One clock edge: check grant/select for s, retire the oldest scoreboard
  // entry against y, then queue the source that y must show next cycle.
  task automatic step(input logic [1:0] s, input logic chk1, input logic [1:0] s1);
    logic [1:0] e;
    @(posedge clk);
    #1;
    check("gnt", 32'({gnt_c, gnt_b, gnt_a}), 32'(gnt_of(s)));
    check("sel", 32'({sel1, sel2}), 32'(s));
    if (yq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = yq.pop_front();
      check("y", 32'(y), 32'(data_of(e)));
      check("y_valid", 32'(y_valid), 32'(e != 2'd3));
    end
    yq.push_back(s);
    if (chk1) begin
      check("gnt_mb1", 32'({gnt1_c, gnt1_b, gnt1_a}), 32'(gnt_of(s1)));
      check("sel_mb1", 32'({sel1_1, sel2_1}), 32'(s1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset with every requester active, before any edge.
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_held");
    #3 rst = 1'b0;
    yq.delete();
    yq.push_back(2'd3);

    // All three held: bursts of four, and per-cycle rotation on MAX_BURST=1.
    for (int i = 0; i < 13; i++)
      step((i < 12) ? 2'(i / 4) : 2'd0, 1'b1, 2'(i % 3));

    // Single requester b across burst boundaries.
    req_a = 1'b0;
    req_c = 1'b0;
    b = 8'h5A;
    for (int i = 0; i < 10; i++)
      step(2'd1, 1'b0, 2'd0);
    req_b = 1'b0;
    step(2'd3, 1'b0, 2'd0);

    // Early release of a hands the mux directly to c.
    b = 8'h22;
    req_a = 1'b1;
    step(2'd0, 1'b0, 2'd0);
    step(2'd0, 1'b0, 2'd0);
    req_a = 1'b0;
    req_c = 1'b1;
    step(2'd2, 1'b0, 2'd0);

    // b takes over; reset lands between edges in its third cycle.
    req_c = 1'b0;
    req_b = 1'b1;
    step(2'd1, 1'b0, 2'd0);
    step(2'd1, 1'b0, 2'd0);
    step(2'd1, 1'b0, 2'd0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_midburst");
    req_a = 1'b1;
    #1 rst = 1'b0;
    yq.delete();
    yq.push_back(2'd3);
    step(2'd0, 1'b0, 2'd0);
    step(2'd0, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
